// File: rtl/booth_r4_seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared types for the sequential radix-4 Booth multiplier:
//            controller states, Booth digit encoding and the triplet decoder.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } digit_t;

    // Triplet is {y[2i+1], y[2i], y[2i-1]}.
    function automatic digit_t booth_decode(input logic [2:0] trip);
        digit_t d;
        case (trip)
            3'b001, 3'b010: d = DIG_POS1;
            3'b011:         d = DIG_POS2;
            3'b100:         d = DIG_NEG2;
            3'b101, 3'b110: d = DIG_NEG1;
            default:        d = DIG_ZERO;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_seq_mult_if
// Purpose  : Operand/result handshake bundle of the sequential Booth
//            multiplier. master = requester/consumer, slave = multiplier.
// Ports    : in_valid/in_ready/x_in/y_in/signed_mode (operand channel),
//            out_valid/out_ready/result_out (result channel), busy (status).
// Revision : 1.0 - initial release
// ============================================================================
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       x_in;
    logic [WIDTH-1:0]       y_in;
    logic                   signed_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result_out;
    logic                   busy;

    modport master (
        output in_valid, x_in, y_in, signed_mode, out_ready,
        input  in_ready, out_valid, result_out, busy
    );

    modport slave (
        input  in_valid, x_in, y_in, signed_mode, out_ready,
        output in_ready, out_valid, result_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/booth_r4_seq_mult_pp_gen.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_pp_gen
// Purpose  : Combinational partial-product selector for one radix-4 Booth
//            digit. Negative digits are produced as the one's complement;
//            the +1 is supplied as carry-in to the accumulator adder.
// Ports    : digit_i   - decoded Booth digit
//            x_ext_i   - multiplicand extended to WIDTH+2 bits
//            pp_o      - WIDTH+3-bit adder operand
//            neg_o     - carry-in completing the two's-complement negation
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  digit_t              digit_i,
    input  logic [WIDTH+1:0]    x_ext_i,
    output logic [WIDTH+2:0]    pp_o,
    output logic                neg_o
);

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        case (digit_i)
            DIG_POS1: pp_o = {x_ext_i[WIDTH+1], x_ext_i};
            DIG_POS2: pp_o = {x_ext_i, 1'b0};
            DIG_NEG1: begin
                pp_o  = ~{x_ext_i[WIDTH+1], x_ext_i};
                neg_o = 1'b1;
            end
            DIG_NEG2: begin
                pp_o  = ~{x_ext_i, 1'b0};
                neg_o = 1'b1;
            end
            default: begin
                pp_o  = '0;
                neg_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_seq_mult
// Purpose  : Sequential radix-4 Booth multiplier, one digit per clock over a
//            single shared adder; signed or unsigned per transaction.
// Ports    : clk, rst (synchronous, active-high)
//            bus (slave) - operand/result valid/ready handshake + busy
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    booth_r4_seq_mult_if.slave      bus
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int XW   = WIDTH + 2;        // extended operand width
    localparam int PPW  = WIDTH + 3;        // partial-product operand width
    localparam int ACCW = 2 * WIDTH + 4;    // accumulator width
    localparam int TOPW = ACCW - WIDTH;     // adder width (upper accumulator field)
    localparam int CNTW = $clog2(ITER);

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q;
    logic [XW-1:0]      y_q;
    logic               yprev_q;            // y[2i-1] of the current triplet
    logic [ACCW-1:0]    acc_q;
    logic [CNTW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] result_q;

    logic               in_ready;
    logic               accept;
    logic               last_digit;
    digit_t             digit;
    logic [PPW-1:0]     pp;
    logic               pp_neg;
    logic [TOPW-1:0]    top_sum;
    logic [ACCW-1:0]    acc_sum;
    logic               x_sx;
    logic               y_sx;

    assign in_ready   = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept     = bus.in_valid && in_ready;
    assign last_digit = (cnt_q == CNTW'(ITER - 1));

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q == BUSY);
    assign bus.result_out = result_q;

    assign x_sx = bus.signed_mode & bus.x_in[WIDTH-1];
    assign y_sx = bus.signed_mode & bus.y_in[WIDTH-1];

    assign digit = booth_decode({y_q[1], y_q[0], yprev_q});

    booth_r4_pp_gen #(
        .WIDTH   (WIDTH)
    ) u_pp_gen (
        .digit_i (digit),
        .x_ext_i (x_q),
        .pp_o    (pp),
        .neg_o   (pp_neg)
    );

    // Partial products are always added at bit WIDTH. The accumulator is
    // shifted right by two after every digit except the last, so the total
    // shift is WIDTH bits and the final accumulator holds the exact product.
    assign top_sum = acc_q[ACCW-1:WIDTH] + {pp[PPW-1], pp} + TOPW'(pp_neg);
    assign acc_sum = {top_sum, acc_q[WIDTH-1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_digit) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            yprev_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            x_q      <= {{2{x_sx}}, bus.x_in};
            y_q      <= {{2{y_sx}}, bus.y_in};
            yprev_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            if (last_digit) begin
                result_q <= acc_sum[2*WIDTH-1:0];
            end else begin
                acc_q   <= {{2{acc_sum[ACCW-1]}}, acc_sum[ACCW-1:2]};
                y_q     <= y_q >> 2;
                yprev_q <= y_q[1];
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_r4_seq_mult
// Purpose  : Self-checking bench for booth_r4_seq_mult: directed cases at
//            WIDTH=16 plus randomized operand/mode sweeps at WIDTH=4/16/32,
//            all checked against an arithmetic reference product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_r4_seq_mult;

    localparam int W  = 16;
    localparam int IT = W / 2 + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult_if #(.WIDTH(W)) bif ();

    booth_r4_seq_mult #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact product of two w-bit operands, low 2w bits, by plain arithmetic.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int w, input bit sm);
        logic [63:0] hi_mask;
        logic [63:0] p;
        hi_mask = ~((64'd1 << w) - 64'd1);
        if (sm && a[w-1]) a = a | hi_mask;
        if (sm && b[w-1]) b = b | hi_mask;
        p = a * b;
        if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    // One full transaction from IDLE; stall = cycles of output backpressure.
    task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input bit sm, input logic [31:0] exp, input int stall);
        int n;
        @(negedge clk);
        bif.x_in        = x;
        bif.y_in        = y;
        bif.signed_mode = sm;
        bif.in_valid    = 1'b1;
        bif.out_ready   = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            bif.in_valid = 1'b0;
            n++;
        end while (!bif.out_valid && n < 60);
        check({tag, " latency"}, 64'(n), 64'(IT + 1));
        check({tag, " result"}, 64'(bif.result_out), 64'(exp));
        repeat (stall) @(negedge clk);
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        check({tag, " release"}, 64'(bif.out_valid), 64'd0);
    endtask

    logic [15:0] bx [3] = '{16'd3, 16'd7, 16'd0};
    logic [15:0] by [3] = '{16'd5, 16'hFFFE, 16'h1234};
    bit          bs [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] be [3] = '{32'd15, 32'hFFFF_FFF2, 32'd0};

    initial begin
        int          n;
        int          seen;
        logic [31:0] held;
        logic [15:0] rx, ry;
        bit          rs;

        rst             = 1'b1;
        bif.in_valid    = 1'b0;
        bif.x_in        = '0;
        bif.y_in        = '0;
        bif.signed_mode = 1'b0;
        bif.out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", 64'(bif.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst out_valid", 64'(bif.out_valid), 64'd0);
        check("rst busy", 64'(bif.busy), 64'd0);
        check("rst result", 64'(bif.result_out), 64'd0);
        check("idle in_ready", 64'(bif.in_ready), 64'd1);

        op16("u_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0);
        op16("s_8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1);
        op16("s_8000x7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 2);
        op16("s_m1xm1",     16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 0);

        // Back-to-back: DONE hands straight over to BUSY.
        @(negedge clk);
        bif.out_ready   = 1'b1;
        bif.in_valid    = 1'b1;
        bif.x_in        = bx[0];
        bif.y_in        = by[0];
        bif.signed_mode = bs[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                n++;
                if (n == 1) check($sformatf("b2b%0d busy", k), 64'(bif.busy), 64'd1);
            end while (!bif.out_valid && n < 60);
            check($sformatf("b2b%0d latency", k), 64'(n), 64'(IT + 1));
            check($sformatf("b2b%0d result", k), 64'(bif.result_out), 64'(be[k]));
            check($sformatf("b2b%0d in_ready", k), 64'(bif.in_ready), 64'd1);
            if (k < 2) begin
                bif.x_in        = bx[k+1];
                bif.y_in        = by[k+1];
                bif.signed_mode = bs[k+1];
            end else begin
                bif.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b end out_valid", 64'(bif.out_valid), 64'd0);
        check("b2b end busy", 64'(bif.busy), 64'd0);
        bif.out_ready = 1'b0;

        // Backpressure in DONE.
        @(negedge clk);
        bif.x_in        = 16'h1234;
        bif.y_in        = 16'h5678;
        bif.signed_mode = 1'b0;
        bif.in_valid    = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            bif.in_valid = 1'b0;
            n++;
        end while (!bif.out_valid && n < 60);
        check("bp result", 64'(bif.result_out), ref_mul(64'h1234, 64'h5678, 16, 1'b0));
        held = bif.result_out;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp out_valid", 64'(bif.out_valid), 64'd1);
            check("bp hold", 64'(bif.result_out), 64'(held));
            check("bp in_ready", 64'(bif.in_ready), 64'd0);
        end
        bif.out_ready = 1'b1;
        #1;
        check("bp ready in DONE", 64'(bif.in_ready), 64'd1);
        @(negedge clk);
        bif.out_ready = 1'b0;
        check("bp out_valid after", 64'(bif.out_valid), 64'd0);
        check("bp idle in_ready", 64'(bif.in_ready), 64'd1);
        check("bp result kept", 64'(bif.result_out), 64'(held));

        // Reset in the middle of 12x12.
        @(negedge clk);
        bif.x_in        = 16'd12;
        bif.y_in        = 16'd12;
        bif.signed_mode = 1'b0;
        bif.in_valid    = 1'b1;
        @(negedge clk);
        bif.in_valid = 1'b0;
        check("mid busy", 64'(bif.busy), 64'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid rst in_ready", 64'(bif.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst out_valid", 64'(bif.out_valid), 64'd0);
        check("mid rst busy", 64'(bif.busy), 64'd0);
        check("mid rst result", 64'(bif.result_out), 64'd0);
        check("mid rst in_ready idle", 64'(bif.in_ready), 64'd1);
        seen = 0;
        repeat (IT + 3) begin
            @(negedge clk);
            if (bif.out_valid) seen++;
        end
        check("mid rst no result", 64'(seen), 64'd0);
        op16("after_rst 2x3", 16'd2, 16'd3, 1'b0, 32'd6, 0);

        for (int i = 0; i < 200; i++) begin
            rx = 16'($urandom());
            ry = 16'($urandom());
            rs = 1'($urandom());
            op16("rnd16", rx, ry, rs, 32'(ref_mul(64'(rx), 64'(ry), 16, rs)),
                 int'($urandom_range(0, 2)));
        end

        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("sweep complete", 64'({g_sweep[1].done, g_sweep[0].done}), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Randomized sweep at the extreme widths, each with its own DUT.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int SW    = (gi == 0) ? 4 : 32;
        localparam int SITER = SW / 2 + 1;

        logic srst;
        bit   done = 1'b0;

        booth_r4_seq_mult_if #(.WIDTH(SW)) sif ();

        booth_r4_seq_mult #(.WIDTH(SW)) u_dut (
            .clk (clk),
            .rst (srst),
            .bus (sif)
        );

        initial begin
            logic [SW-1:0] xr, yr;
            bit            sm;
            int            n;

            srst            = 1'b1;
            sif.in_valid    = 1'b0;
            sif.x_in        = '0;
            sif.y_in        = '0;
            sif.signed_mode = 1'b0;
            sif.out_ready   = 1'b0;
            repeat (2) @(negedge clk);
            srst = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                xr = SW'($urandom());
                yr = SW'($urandom());
                sm = 1'($urandom());
                if (i == 0) begin
                    xr = '1;
                    yr = '1;
                    sm = 1'b0;
                end else if (i == 1) begin
                    xr = '0;
                    xr[SW-1] = 1'b1;
                    yr = xr;
                    sm = 1'b1;
                end
                @(negedge clk);
                sif.x_in        = xr;
                sif.y_in        = yr;
                sif.signed_mode = sm;
                sif.in_valid    = 1'b1;
                n = 0;
                do begin
                    @(posedge clk);
                    @(negedge clk);
                    sif.in_valid = 1'b0;
                    n++;
                end while (!sif.out_valid && n < 60);
                check($sformatf("w%0d latency", SW), 64'(n), 64'(SITER + 1));
                check($sformatf("w%0d x=%0h y=%0h s=%0d", SW, xr, yr, sm),
                      64'(sif.result_out), ref_mul(64'(xr), 64'(yr), SW, sm));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sif.out_ready = 1'b1;
                @(negedge clk);
                sif.out_ready = 1'b0;
            end
            done = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
Parametrised, sequential radix-4 Booth multiplier. It is the area-optimised successor to the combinational 16-bit Booth/Wallace multiplier, and the natural choice where a full array is too large. It iterates one radix-4 Booth digit per clock over a shared adder, supports signed or unsigned operands per transaction, and uses valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and >= 4.
- ITER, WIDTH/2+1, derived (localparam, not overridable): number of Booth digits processed per operation.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operand pair.
- x_in  input  WIDTH  multiplicand.
- y_in  input  WIDTH  multiplier.
- signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned. Sampled with the operands.
- out_valid  output  1  result_out holds a completed product.
- out_ready  input  1  consumer accepts result.
- result_out  output  2*WIDTH  product (registered).
- busy  output  1  high while in BUSY state.

Behaviour:
- Reset (rst high at a rising edge):
  - state goes to IDLE; out_valid=0, busy=0, result_out=0; accumulator and iteration counter cleared.
  - in_ready=0 while rst is high.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. If in_valid is high at an edge, go to BUSY.
  - BUSY: in_ready=0, busy=1. One digit is processed per edge. After the ITER-th digit, go to DONE.
  - DONE: out_valid=1.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: accept the new operands and go straight to BUSY (back-to-back).
    - out_ready=0: stay in DONE; result_out is held stable.
- in_ready = (state==IDLE) | (state==DONE & out_ready), gated by !rst. It is combinational, from state and out_ready only, and never depends on in_valid.
- Acceptance edge:
  - Latch x_in and y_in, each extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - Clear the accumulator and the digit counter.
- Digit i (i = 0..ITER-1):
  - Triplet {y[2i+1], y[2i], y[2i-1]} from the extended multiplier, with y[-1]=0.
  - Booth mapping: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
  - The partial product is added at weight 4^i. Implementation is a right-shifting accumulator of width 2*WIDTH+4; negation uses invert plus carry-in on the same adder.
- Latency: an operand pair accepted at edge T gives out_valid visible after edge T+ITER (9 edges for WIDTH=16). Latency is fixed and independent of operand values and mode.
- result_out:
  - Equals the low 2*WIDTH bits of the exact product, loaded on the transition into DONE.
  - Holds its value after the output handshake until the next completion; it is not cleared.
- Unsigned mode: the extra digit (ITER = WIDTH/2+1) guarantees a correct product for operands with MSB=1.
- Overflow: none possible; a 2*WIDTH-bit result is exact in both modes.
- in_valid asserted while BUSY is ignored, since in_ready=0. The upstream must hold its data until the handshake.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Booth digit enum {DIG_ZERO, DIG_POS1, DIG_POS2, DIG_NEG1, DIG_NEG2}.
  - Function booth_decode(3-bit triplet) returning the digit.
- Sub-module booth_r4_pp_gen (combinational):
  - Inputs: digit and the extended multiplicand.
  - Outputs: the WIDTH+3-bit partial-product operand and the negate carry-in.
- The top level holds the FSM, counter, accumulator, adder and handshake.

Test Plan:
- Unsigned, WIDTH=16, x=0xFFFF, y=0xFFFF, signed_mode=0 -> result_out=0xFFFE0001, out_valid after 9 edges.
- Signed: x=0x8000, y=0x8000 -> 0x40000000. Also x=0x8000, y=0x7FFF -> 0xC0008000. Also x=0xFFFF, y=0xFFFF -> 0x00000001.
- Back-to-back: hold out_ready=1, in_valid=1, and present three pairs (3×5, 7×(-2) signed, 0×0x1234). Expect results 15, 0xFFFFFFF2, 0 with no idle cycle between each DONE and the next BUSY.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, result_out stays constant, in_ready=0. Then out_ready=1 -> one handshake and a return to IDLE.
- Reset mid-op: assert rst at BUSY digit 4 of 12×12 -> after the edge, state is IDLE, out_valid=0, result_out=0. A new pair 2×3 then completes to 6.
- Parameter sweep: WIDTH=4 and WIDTH=32. Run 1000 random operand/mode pairs each and check against a reference product, with latency ITER=3 and ITER=17 respectively.
